// File: rtl/game_timer.sv
// Game timer: counts slow ticks while the player is alive, freezes after a death,
// holds on the win screen and clears on the menu screen.
module game_timer #(
    parameter int DEATH_TICKS = 20,
    parameter int TIME_MAX    = 2047
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slowClk,
    input  logic        menuScreen,
    input  logic        winScreen,
    input  logic        collision,
    output logic [10:0] game_time,
    output logic        playerDied,
    output logic        frozen,
    output logic [3:0]  deaths,
    output logic        tick
);

    localparam logic [10:0] TMAX   = 11'(TIME_MAX);
    localparam logic [4:0]  DTICKS = 5'(DEATH_TICKS);

    typedef enum logic [1:0] {IDLE, RUN, DYING, DONE} state_t;

    logic [1:0]  sync_q;
    logic        prev_q;
    logic        tick_q;
    logic        tick_d;
    state_t      state_q;
    logic [10:0] time_q;
    logic [3:0]  deaths_q;
    logic [4:0]  freeze_q;
    logic        died_q;
    logic        frozen_q;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    assign tick_d = sync_q[1] & ~prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], slowClk};
            prev_q <= sync_q[1];
            tick_q <= tick_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            time_q   <= '0;
            deaths_q <= '0;
            freeze_q <= '0;
            died_q   <= 1'b0;
            frozen_q <= 1'b0;
        end else begin
            died_q <= 1'b0;
            if (menuScreen) begin
                state_q  <= IDLE;
                time_q   <= '0;
                deaths_q <= '0;
                freeze_q <= '0;
                frozen_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!winScreen) state_q <= RUN;
                    end
                    RUN: begin
                        if (winScreen) begin
                            state_q <= DONE;
                        end else if (collision) begin
                            // A tick landing on the death edge is dropped.
                            state_q  <= DYING;
                            died_q   <= 1'b1;
                            time_q   <= '0;
                            freeze_q <= DTICKS;
                            frozen_q <= 1'b1;
                            if (deaths_q != 4'd15) deaths_q <= deaths_q + 4'd1;
                        end else if (tick_q && time_q != TMAX) begin
                            time_q <= time_q + 11'd1;
                        end
                    end
                    DYING: begin
                        if (winScreen) begin
                            state_q  <= DONE;
                            frozen_q <= 1'b0;
                        end else if (tick_q) begin
                            freeze_q <= freeze_q - 5'd1;
                            if (freeze_q == 5'd1) begin
                                state_q  <= RUN;
                                frozen_q <= 1'b0;
                            end
                        end
                    end
                    DONE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign game_time  = time_q;
    assign playerDied = died_q;
    assign frozen     = frozen_q;
    assign deaths     = deaths_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: tick generation, run/death/freeze/win flow,
// saturation limits and asynchronous reset.
module tb_game_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        slowClk;
    logic        menuScreen;
    logic        winScreen;
    logic        collision;
    logic [10:0] game_time;
    logic        playerDied;
    logic        frozen;
    logic [3:0]  deaths;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int n;

    game_timer dut (
        .clk        (clk),
        .reset      (reset),
        .slowClk    (slowClk),
        .menuScreen (menuScreen),
        .winScreen  (winScreen),
        .collision  (collision),
        .game_time  (game_time),
        .playerDied (playerDied),
        .frozen     (frozen),
        .deaths     (deaths),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One slowClk pulse; called and returns on a falling clk edge.
    task automatic do_tick();
        slowClk = 1'b1;
        cyc();
        cyc();
        check("tick_before", tick, 0);
        cyc();
        check("tick_high", tick, 1);
        cyc();
        check("tick_width", tick, 0);
        slowClk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic go_menu();
        menuScreen = 1'b1;
        cyc();
        menuScreen = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; slowClk = 1'b0; menuScreen = 1'b1;
        winScreen = 1'b0; collision = 1'b0;
        #1;
        check("rst_time", game_time, 0);
        check("rst_deaths", deaths, 0);
        check("rst_died", playerDied, 0);
        check("rst_frozen", frozen, 0);
        check("rst_tick", tick, 0);
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check("menu_time", game_time, 0);

        // Count 130 ticks from zero
        menuScreen = 1'b0;
        cyc();
        check("run_start", game_time, 0);
        for (int i = 1; i <= 130; i++) begin
            do_tick();
            check("count", game_time, i);
        end

        // Death at game_time 77 with a 5-cycle collision
        go_menu();
        check("menu_clear", game_time, 0);
        for (int i = 0; i < 77; i++) do_tick();
        check("pre_death", game_time, 77);
        collision = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (playerDied) n++;
        end
        collision = 1'b0;
        check("died_pulses", n, 1);
        check("death_time", game_time, 0);
        check("death_cnt", deaths, 1);
        check("death_frozen", frozen, 1);

        // Freeze lasts 20 ticks; the 21st counts
        for (int i = 0; i < 19; i++) do_tick();
        check("frozen_19", frozen, 1);
        check("frozen_time", game_time, 0);
        do_tick();
        check("frozen_20", frozen, 0);
        check("resume_time", game_time, 0);
        do_tick();
        check("tick_21", game_time, 1);

        // Collision on the same edge as a tick
        do_tick();
        do_tick();
        check("pre_coinc", game_time, 3);
        slowClk = 1'b1;
        cyc();
        cyc();
        cyc();
        check("coinc_tick", tick, 1);
        collision = 1'b1;
        cyc();
        check("coinc_time", game_time, 0);
        check("coinc_died", playerDied, 1);
        check("coinc_deaths", deaths, 2);
        collision = 1'b0;
        slowClk = 1'b0;
        cyc();
        check("coinc_once", playerDied, 0);
        repeat (2) cyc();
        for (int i = 0; i < 20; i++) do_tick();
        check("coinc_resume", frozen, 0);

        // Win screen holds the time
        go_menu();
        for (int i = 0; i < 1301; i++) do_tick();
        check("pre_win", game_time, 1301);
        winScreen = 1'b1;
        cyc();
        n = 0;
        for (int i = 0; i < 3; i++) do_tick();
        collision = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (playerDied) n++;
        end
        collision = 1'b0;
        do_tick();
        check("win_hold", game_time, 1301);
        check("win_deaths", deaths, 0);
        check("win_no_death", n, 0);
        winScreen = 1'b0;
        menuScreen = 1'b1;
        cyc();
        check("win_menu_time", game_time, 0);
        check("win_menu_deaths", deaths, 0);
        menuScreen = 1'b0;
        cyc();

        // Death counter saturation
        for (int i = 1; i <= 16; i++) begin
            collision = 1'b1;
            cyc();
            collision = 1'b0;
            for (int k = 0; k < 20; k++) do_tick();
            check("deaths_sat", deaths, (i > 15) ? 15 : i);
        end

        // Time saturation
        for (int i = 1; i <= 2100; i++) begin
            do_tick();
            if (i == 2046 || i == 2047 || i == 2048 || i == 2100)
                check("time_sat", game_time, (i > 2047) ? 2047 : i);
        end

        // Reset mid-DYING, right as the death pulse is out
        collision = 1'b1;
        cyc();
        collision = 1'b0;
        check("pre_rst_died", playerDied, 1);
        check("pre_rst_frozen", frozen, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_died", playerDied, 0);
        check("mid_rst_frozen", frozen, 0);
        check("mid_rst_deaths", deaths, 0);
        check("mid_rst_time", game_time, 0);
        check("mid_rst_tick", tick, 0);
        slowClk = 1'b1;
        repeat (4) cyc();
        check("rst_hold_tick", tick, 0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tick) n++;
        end
        check("post_rst_ticks", n, 1);
        check("post_rst_time", game_time, 1);
        check("post_rst_died", playerDied, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
